// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared types and defaults for the 1:N stream demux
//
// Purpose: default data width and channel count, routing FSM state encoding,
//          and the payload layout held in each output slot.
// Ports:   none (package).

package stream_demux_pkg;

  localparam int DEF_W = 4;
  localparam int DEF_N = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_W-1:0] data;
    logic             last;
  } slot_payload_t;

endpackage

// File: rtl/stream_slot.sv
// rtl/stream_slot.sv - one-entry registered output slot of the stream demux
//
// Purpose: holds a single beat (data + last) for one output channel.
//          A write and a drain in the same cycle keep the slot full and load
//          the new beat, so a channel streaming at full rate sees no bubble.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   i_wr_en    - load i_wr_data/i_wr_last this edge (caller guarantees room)
//   i_wr_data  - beat payload to store
//   i_wr_last  - beat last flag to store
//   i_ready    - downstream consumer ready
//   o_valid    - slot holds a beat for the consumer
//   o_data     - stored payload (held after drain, don't-care while invalid)
//   o_last     - stored last flag
//   o_full     - slot occupancy, same as o_valid, for the upstream ready logic

module stream_slot #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_wr_last,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic         o_full
);

  logic         r_full;
  logic [W-1:0] r_data;
  logic         r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (i_wr_en) begin
      // Covers both the empty-slot write and the drain-and-reload case.
      r_full <= 1'b1;
      r_data <= i_wr_data;
      r_last <= i_wr_last;
    end else if (r_full && i_ready) begin
      r_full <= 1'b0;
    end
  end

  assign o_valid = r_full;
  assign o_full  = r_full;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/stream_demux_1_4.sv
// rtl/stream_demux_1_4.sv - packet-sticky 1:N valid/ready stream demultiplexer
//
// Purpose: routes one input stream to one of N output slots. The destination
//          is taken from in_sel on the first beat of a packet and locked until
//          the beat carrying in_last, so packets never interleave on a channel.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   in_data/in_sel/
//   in_last/in_valid    - input beat, destination (first beat only), last flag
//   in_ready            - beat accepted this cycle when in_valid is also high
//   out_data            - channel k payload at [k*W +: W]
//   out_last/out_valid  - per-channel last flag and slot-full
//   out_ready           - per-channel consumer ready
//   busy                - mid-packet (destination locked)

module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int N  = DEF_N,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    in_data,
  input  logic [SW-1:0]   in_sel,
  input  logic            in_last,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N-1:0]    out_last,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic            busy
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_lock_sel;
  logic [SW-1:0] w_lock_nxt;
  logic [SW-1:0] w_target;
  logic          w_accept;
  logic [N-1:0]  w_wr_en;
  logic [N-1:0]  w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lock_sel <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_sel <= w_lock_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_sel;
    w_target    = in_sel;
    w_wr_en     = '0;

    if (r_state == ST_PKT) begin
      w_target = r_lock_sel;
    end

    // Ready depends only on the target slot, never on in_valid.
    in_ready = !w_full[w_target] || out_ready[w_target];
    w_accept = in_valid && in_ready;

    if (w_accept) begin
      w_wr_en[w_target] = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        // A single-beat packet (in_last on the first beat) never locks.
        if (w_accept && !in_last) begin
          w_state_nxt = ST_PKT;
          w_lock_nxt  = in_sel;
        end
      end
      ST_PKT: begin
        if (w_accept && in_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (r_state == ST_PKT);

  for (genvar k = 0; k < N; k++) begin : g_slot
    stream_slot #(
      .W (W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en[k]),
      .i_wr_data (in_data),
      .i_wr_last (in_last),
      .i_ready   (out_ready[k]),
      .o_valid   (out_valid[k]),
      .o_data    (out_data[k*W +: W]),
      .o_last    (out_last[k]),
      .o_full    (w_full[k])
    );
  end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// tb/tb_stream_demux_1_4.sv - directed self-checking bench for stream_demux_1_4

module tb_stream_demux_1_4;

  logic        clk;
  logic        rst;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_last;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        busy;

  int n_cmp;
  int n_err;

  stream_demux_1_4 dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic drive(input logic [1:0] sel, input logic [3:0] data,
                       input logic last, input logic valid);
    in_sel   = sel;
    in_data  = data;
    in_last  = last;
    in_valid = valid;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 4'b1111;
    drive(2'd0, 4'h0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL reset_out_valid: got %b expected %b", out_valid, 4'b0000);
    end
    n_cmp++;
    if (out_data !== 16'h0000) begin
      n_err++; $display("FAIL reset_out_data: got %h expected %h", out_data, 16'h0000);
    end
    n_cmp++;
    if (out_last !== 4'b0000) begin
      n_err++; $display("FAIL reset_out_last: got %b expected %b", out_last, 4'b0000);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected %b", in_ready, 1'b1);
    end
  endtask

  task automatic test_single_beat();
    out_ready = 4'b1111;
    drive(2'd2, 4'hA, 1'b1, 1'b1);
    step();
    drive(2'd0, 4'h0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (out_valid !== 4'b0100) begin
      n_err++; $display("FAIL single_valid: got %b expected %b", out_valid, 4'b0100);
    end
    n_cmp++;
    if (out_data[11:8] !== 4'hA) begin
      n_err++; $display("FAIL single_data: got %h expected %h", out_data[11:8], 4'hA);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL single_busy: got %b expected %b", busy, 1'b0);
    end
    step();
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL single_drain: got %b expected %b", out_valid, 4'b0000);
    end
  endtask

  task automatic test_sticky();
    logic [1:0] sels [3];
    sels[0] = 2'd1; sels[1] = 2'd3; sels[2] = 2'd0;
    out_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      drive(sels[i], 4'(i + 1), (i == 2), 1'b1);
      step();
      #1;
      n_cmp++;
      if (out_valid !== 4'b0010 || out_data[7:4] !== 4'(i + 1) || out_last[1] !== (i == 2)) begin
        n_err++;
        $display("FAIL sticky_beat%0d: got valid=%b data=%h last=%b expected valid=0010 data=%h last=%b",
                 i, out_valid, out_data[7:4], out_last[1], 4'(i + 1), (i == 2));
      end
      n_cmp++;
      if (busy !== (i != 2)) begin
        n_err++; $display("FAIL sticky_busy%0d: got %b expected %b", i, busy, (i != 2));
      end
    end
    drive(2'd0, 4'h0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1110;
    drive(2'd0, 4'h7, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_first_ready: got %b expected %b", in_ready, 1'b1);
    end
    step();
    drive(2'd0, 4'h8, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_second_stalled: got %b expected %b", in_ready, 1'b0);
    end
    step();
    #1;
    n_cmp++;
    if (out_valid[0] !== 1'b1 || out_data[3:0] !== 4'h7) begin
      n_err++; $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=7", out_valid[0], out_data[3:0]);
    end
    out_ready = 4'b1111;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release_ready: got %b expected %b", in_ready, 1'b1);
    end
    step();
    drive(2'd0, 4'h0, 1'b0, 1'b0);
    out_ready = 4'b1110;
    #1;
    n_cmp++;
    if (out_valid[0] !== 1'b1 || out_data[3:0] !== 4'h8) begin
      n_err++; $display("FAIL bp_reload: got valid=%b data=%h expected valid=1 data=8", out_valid[0], out_data[3:0]);
    end
  endtask

  // Relies on ch0 left full (data 8) and stalled by test_backpressure.
  task automatic test_isolation();
    drive(2'd3, 4'h5, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL iso_ready: got %b expected %b", in_ready, 1'b1);
    end
    step();
    drive(2'd0, 4'h0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (out_valid !== 4'b1001 || out_data[15:12] !== 4'h5 || out_data[3:0] !== 4'h8) begin
      n_err++;
      $display("FAIL iso_deliver: got valid=%b ch3=%h ch0=%h expected valid=1001 ch3=5 ch0=8",
               out_valid, out_data[15:12], out_data[3:0]);
    end
    out_ready = 4'b1111;
    step();
    step();
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL iso_drain: got %b expected %b", out_valid, 4'b0000);
    end
  endtask

  task automatic test_full_rate();
    int stalls;
    int bad;
    stalls = 0;
    bad = 0;
    out_ready = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      drive(2'd2, 4'(i), (i == 15), 1'b1);
      #1;
      if (in_ready !== 1'b1) stalls++;
      step();
      #1;
      if (out_valid !== 4'b0100 || out_data[11:8] !== 4'(i)) bad++;
    end
    drive(2'd0, 4'h0, 1'b0, 1'b0);
    n_cmp++;
    if (stalls !== 0) begin
      n_err++; $display("FAIL rate_stalls: got %0d expected %0d", stalls, 0);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++; $display("FAIL rate_sequence: got %0d bad beats expected %0d", bad, 0);
    end
    n_cmp++;
    if (busy !== 1'b0 || out_last[2] !== 1'b1) begin
      n_err++; $display("FAIL rate_end: got busy=%b last=%b expected busy=0 last=1", busy, out_last[2]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b0000;
    drive(2'd1, 4'h1, 1'b0, 1'b1);
    step();
    drive(2'd1, 4'h2, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL rmid_stall: got %b expected %b", in_ready, 1'b0);
    end
    out_ready = 4'b0010;
    step();
    drive(2'd0, 4'h0, 1'b0, 1'b0);
    out_ready = 4'b0000;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 4'b0010 || out_data[7:4] !== 4'h2) begin
      n_err++;
      $display("FAIL rmid_pre: got busy=%b valid=%b ch1=%h expected busy=1 valid=0010 ch1=2",
               busy, out_valid, out_data[7:4]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL rmid_cleared: got valid=%b busy=%b expected valid=0000 busy=0", out_valid, busy);
    end
    out_ready = 4'b1111;
    drive(2'd3, 4'h9, 1'b0, 1'b1);
    step();
    drive(2'd1, 4'hB, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (out_valid !== 4'b1000 || out_data[15:12] !== 4'h9 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_reroute: got valid=%b ch3=%h busy=%b expected valid=1000 ch3=9 busy=1",
               out_valid, out_data[15:12], busy);
    end
    step();
    drive(2'd0, 4'h0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (out_valid !== 4'b1000 || out_data[15:12] !== 4'hB || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_tail: got valid=%b ch3=%h busy=%b expected valid=1000 ch3=b busy=0",
               out_valid, out_data[15:12], busy);
    end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    out_ready = 4'b1111;
    drive(2'd0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_sticky();
    test_backpressure();
    test_isolation();
    test_full_rate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
